rr_dec_arbiter_4: RTL and testbench
===================================

RR_DEC_ARBITER_4 -- requirements
Module: rr_dec_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one owner holds the grant; legal range 1..7.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  4  request lines; bit i high = requester i wants the shared resource.
REQ-005 The block SHALL have port gnt  output  4  registered one-hot grant; bit i high = requester i owns the resource.
REQ-006 The block SHALL have port gnt_idx  output  2  registered binary index of the current owner.
REQ-007 The block SHALL have port gnt_vld  output  1  registered; high while any grant is active (decoder enable).

Function
REQ-008 The block SHALL always keep gnt equal to the 2-to-4 decode of gnt_idx enabled by gnt_vld: gnt_vld=0 -> gnt=0000; gnt_vld=1 -> only bit gnt_idx set.
REQ-009 The block SHALL implement two states: IDLE (no owner) and BUSY (owner = gnt_idx).
REQ-010 The block SHALL keep an internal last-owner pointer `last` (2 bits) and a hold counter hold_cnt (3 bits).
REQ-011 The block SHALL perform arbitration as a rotating-priority search, in the order last+1, last+2, last+3, last (mod 4), returning the first set req bit.
REQ-012 In IDLE with req=0000, the block SHALL remain in IDLE with outputs unchanged.
REQ-013 In IDLE with any req bit set at edge N, the block SHALL, on edge N, load gnt_idx with the arbitration winner, set gnt_vld=1, set hold_cnt=1, and enter BUSY; the grant is visible in the cycle after the request is sampled (1-cycle latency).
REQ-014 In BUSY with req[gnt_idx]=1 and hold_cnt<MAX_HOLD, the block SHALL keep the grant unchanged and increment hold_cnt.
REQ-015 In BUSY, a release event is req[gnt_idx]=0, or hold_cnt=MAX_HOLD with req[gnt_idx]=1; on release the block SHALL set last=gnt_idx and arbitrate in the same cycle using the updated `last`.
REQ-016 On release with any req bit set, the block SHALL grant the winner on the same edge with hold_cnt=1, with no idle bubble between owners.
REQ-017 On release with req=0000, the block SHALL clear gnt_vld and enter IDLE; gnt_idx SHALL retain its value.
REQ-018 On hold expiry with only the current owner requesting, the block SHALL re-grant the same owner continuously (gnt stays high) with hold_cnt restarted at 1.
REQ-019 With MAX_HOLD=1, the block SHALL re-arbitrate every cycle, so persistent requesters rotate each cycle.
REQ-020 The block SHALL never produce more than one gnt bit high and SHALL never grant a requester whose req bit was low at the deciding edge.
REQ-021 The block SHALL guarantee each persistent requester a grant within 3*MAX_HOLD+1 cycles of raising req.

Reset
REQ-022 On any edge with rst=1, the block SHALL take state=IDLE, gnt=0000, gnt_idx=00, gnt_vld=0, hold_cnt=0, and last=3, so that requester 0 has first priority.
REQ-023 The block SHALL give rst priority over all other inputs, including in the middle of a grant; the first arbitration SHALL occur on the first edge with rst=0.

Verification
REQ-024 rst held 2 cycles with req=0000, then released -> gnt=0000, gnt_vld=0, gnt_idx=00 on every cycle.
REQ-025 After reset, req=1111 held and MAX_HOLD=4 -> gnt=0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again, with gnt_vld=1 throughout.
REQ-026 After reset, req=0100 for 2 cycles, then req=0001 -> gnt=0100 for 2 cycles, then gnt=0001 on the very next cycle with no 0000 gap.
REQ-027 After reset, req=1000 held 10 cycles -> gnt=1000 and gnt_idx=11 for all 10 cycles, with hold_cnt wrapping 1..4.
REQ-028 req=1111 with the grant at 0100 and hold_cnt=2, then rst pulsed 1 cycle -> gnt=0000 the following cycle, then gnt=0001 on the first edge with rst=0.
REQ-029 Owner 0010 drops req while the others hold 0000 -> gnt=0000 and gnt_vld=0 the next cycle; a later req=0011 -> grant 0001 (rotation from last=1 visits 2, 3, then 0).

Source files
------------

// File: rtl/rr_dec_arbiter_4.sv
`default_nettype none
// ============================================================================
// rr_dec_arbiter_4 : 4-way rotating-priority arbiter with bounded hold and a
//                    decoded one-hot grant.       Revision: 1.0
// ============================================================================
module rr_dec_arbiter_4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] HOLD_MAX = 3'(MAX_HOLD);

  state_t     state;
  logic [2:0] hold_cnt;
  logic [1:0] last;

  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       found;
  logic       keep;

  // On release the outgoing owner becomes the new `last`, so the search
  // starts right after gnt_idx without waiting a cycle for `last` to update.
  always_comb begin
    base   = (state == BUSY) ? gnt_idx : last;
    winner = base;
    found  = 1'b0;
    cand   = base;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    keep = req[gnt_idx] && (hold_cnt < HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'b00;
      gnt_vld  <= 1'b0;
      hold_cnt <= 3'd0;
      last     <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BUSY;
            gnt_idx  <= winner;
            gnt      <= 4'b0001 << winner;
            gnt_vld  <= 1'b1;
            hold_cnt <= 3'd1;
          end
        end
        BUSY: begin
          if (keep) begin
            hold_cnt <= hold_cnt + 3'd1;
          end else begin
            last <= gnt_idx;
            if (found) begin
              gnt_idx  <= winner;
              gnt      <= 4'b0001 << winner;
              hold_cnt <= 3'd1;
            end else begin
              state    <= IDLE;
              gnt      <= 4'b0000;
              gnt_vld  <= 1'b0;
              hold_cnt <= 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_dec_arbiter_4.sv
`default_nettype none
// ============================================================================
// tb_rr_dec_arbiter_4 : scoreboard bench for rr_dec_arbiter_4 (MAX_HOLD 4 and 1)
// Revision: 1.0
// ============================================================================
module tb_rr_dec_arbiter_4;

  typedef struct packed {
    logic            rst;
    logic [3:0]      req;
    logic [1:0][3:0] gnt;
    logic [1:0][1:0] idx;
    logic [1:0]      vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;

  int checks   = 0;
  int failures = 0;

  exp_t sbq[$];

  // reference model state, one slot per DUT instance; owner < 0 means idle
  int maxh[2]  = '{4, 1};
  int owner[2] = '{-1, -1};
  int held[2]  = '{0, 0};
  int lastp[2] = '{3, 3};
  int kidx[2]  = '{0, 0};

  always #5 clk = ~clk;

  rr_dec_arbiter_4 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
  );

  rr_dec_arbiter_4 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
  );

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle and record what the outputs must be after the next edge
  task automatic step(input logic r_in, input logic [3:0] q_in);
    exp_t e;
    @(negedge clk);
    rst = r_in;
    req = q_in;
    for (int m = 0; m < 2; m++) begin
      if (r_in) begin
        owner[m] = -1; held[m] = 0; lastp[m] = 3; kidx[m] = 0;
      end else if (owner[m] < 0) begin
        if (q_in != 4'b0000) begin
          owner[m] = pick(q_in, lastp[m]);
          held[m]  = 1;
        end
      end else if (q_in[owner[m]] && held[m] < maxh[m]) begin
        held[m]++;
      end else begin
        lastp[m] = owner[m];
        if (q_in != 4'b0000) begin
          owner[m] = pick(q_in, lastp[m]);
          held[m]  = 1;
        end else begin
          kidx[m]  = owner[m];
          owner[m] = -1;
          held[m]  = 0;
        end
      end
      if (owner[m] >= 0) kidx[m] = owner[m];
      e.gnt[m] = (owner[m] >= 0) ? 4'(1 << owner[m]) : 4'b0000;
      e.idx[m] = 2'(kidx[m]);
      e.vld[m] = (owner[m] >= 0);
    end
    e.rst = r_in;
    e.req = q_in;
    sbq.push_back(e);
  endtask

  task automatic hold_req(input logic [3:0] q_in, input int n);
    for (int i = 0; i < n; i++) step(1'b0, q_in);
  endtask

  // monitor: pops one expectation per clock edge and compares both DUTs
  initial begin : monitor
    exp_t       e;
    logic [3:0] ag[2];
    logic [1:0] ai[2];
    logic       av[2];
    int         wait_cnt[4];
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        ag[0] = gnt_a; ai[0] = idx_a; av[0] = vld_a;
        ag[1] = gnt_b; ai[1] = idx_b; av[1] = vld_b;
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("gnt[%0d]", m), int'(ag[m]), int'(e.gnt[m]));
          chk($sformatf("gnt_idx[%0d]", m), int'(ai[m]), int'(e.idx[m]));
          chk($sformatf("gnt_vld[%0d]", m), int'(av[m]), int'(e.vld[m]));
          chk($sformatf("onehot0[%0d]", m), int'($onehot0(ag[m])), 1);
          if (!e.rst)
            chk($sformatf("gnt_subset_req[%0d]", m), int'(ag[m] & ~e.req), 0);
        end
        for (int i = 0; i < 4; i++) begin
          if (e.rst || !e.req[i] || gnt_a[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          if (wait_cnt[i] > 0)
            chk($sformatf("wait_bound_req%0d", i), int'(wait_cnt[i] <= 3 * 4 + 1), 1);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] r;
    // reset held then released with no requests
    step(1'b1, 4'b0000); step(1'b1, 4'b0000);
    hold_req(4'b0000, 3);
    // full contention rotation
    step(1'b1, 4'b0000);
    hold_req(4'b1111, 20);
    // handover without a bubble
    step(1'b1, 4'b0000);
    hold_req(4'b0100, 2);
    hold_req(4'b0001, 3);
    // single persistent requester re-granted across hold expiry
    step(1'b1, 4'b0000);
    hold_req(4'b1000, 10);
    // reset in the middle of a grant (owner 2, hold 2)
    step(1'b1, 4'b0000);
    hold_req(4'b1111, 10);
    step(1'b1, 4'b1111);
    hold_req(4'b1111, 3);
    // owner drops with no other request, then rotation from last=1
    step(1'b1, 4'b0000);
    hold_req(4'b0010, 2);
    hold_req(4'b0000, 2);
    hold_req(4'b0011, 3);
    // randomized traffic with occasional reset
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) < 2) r[b] = ~r[b];
      step(($urandom_range(0, 59) == 0), r);
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
